i2c_codec_reg_slave: RTL and testbench

- I2C target (responder) that models the audio codec's control port. It accepts the 3-byte register writes the configuration sequencer issues: a device address byte, then a 16-bit word made of a 7-bit register index and 9-bit data.
- Decodes each write into a 10-entry register file and pulses a write strobe per committed register.
- Used as a synthesizable codec stand-in and as a self-checking target for the config path.

---
 rtl/i2c_codec_reg_slave.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_i2c_codec_reg_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_reg_slave.sv
// rtl/i2c_codec_reg_slave.sv - I2C codec control-port target with 10-entry register file (read-back enabled by I2C_SLV_RD_EN)
module i2c_codec_reg_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         NUM_REGS    = 10,
    parameter logic [6:0] RESET_REG   = 7'h0F,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       oREG_WE,
    output logic [6:0] oREG_ADDR,
    output logic [8:0] oREG_DATA,
    input  logic [3:0] iRD_IDX,
    output logic [8:0] oRD_DATA,
    output logic       oBUSY,
    output logic [7:0] oERR_CNT
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2,
        S_OVERRUN, S_IGNORE, S_RD_ACK, S_TX, S_TX_MACK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_dly_q, sda_dly_q;
    logic                   scl, sda, scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, shift_in;
    logic [7:0] hi_q, hi_d;
    logic       ack_on_q, ack_on_d;
    logic       sda_oe_q, sda_oe_d;
    logic       we_q, we_d;
    logic [6:0] addr_q, addr_d;
    logic [8:0] data_q, data_d;
    logic [7:0] err_q, err_d;
    logic       err_inc, partial, last_bit, addr_wr, addr_rd;
    logic [8:0] regs_q [NUM_REGS];
    logic [8:0] regs_d [NUM_REGS];

`ifdef I2C_SLV_RD_EN
    logic [6:0] ptr_q, ptr_d;
    logic [7:0] tx_q, tx_d;
    logic       tx_second_q, tx_second_d;
    logic [8:0] ptr_data;
`endif

    function automatic logic [8:0] reg_default(input int idx);
        case (idx)
            0, 1:    reg_default = 9'h097;
            2, 3:    reg_default = 9'h079;
            4:       reg_default = 9'h00A;
            5:       reg_default = 9'h008;
            6:       reg_default = 9'h09F;
            7:       reg_default = 9'h00A;
            default: reg_default = 9'h000;
        endcase
    endfunction

    // Open-drain data line: only ever pull low or release
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

    // Bus synchronizers plus one delay stage for edge detection; idle-high on reset
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], I2C_SDAT};
            scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
            sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_sync_q[SYNC_STAGES-1];
    assign sda       = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_dly_q;
    assign scl_fall  = ~scl & scl_dly_q;
    assign start_det = scl & scl_dly_q & sda_dly_q & ~sda;
    assign stop_det  = scl & scl_dly_q & ~sda_dly_q & sda;
    assign shift_in  = {shift_q[6:0], sda};
    assign last_bit  = scl_rise && (bit_cnt_q == 4'd7);
    assign addr_wr   = (shift_in == {DEV_ADDR, 1'b0});
`ifdef I2C_SLV_RD_EN
    assign addr_rd   = (shift_in == {DEV_ADDR, 1'b1});
`else
    assign addr_rd   = 1'b0;
`endif

    // A write word is in flight from the first address bit until the commit
    assign partial = (state_q == S_ACK_A) || (state_q == S_BYTE1) || (state_q == S_ACK_1) ||
                     (state_q == S_BYTE2) || ((state_q == S_ADDR) && (bit_cnt_q != 4'd0));

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; bus START/STOP override any bit-level progress
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = S_IDLE;
        end else if (start_det) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR:    if (last_bit) state_d = addr_wr ? S_ACK_A : (addr_rd ? S_RD_ACK : S_IGNORE);
                S_ACK_A:   if (scl_fall && ack_on_q) state_d = S_BYTE1;
                S_BYTE1:   if (last_bit) state_d = S_ACK_1;
                S_ACK_1:   if (scl_fall && ack_on_q) state_d = S_BYTE2;
                S_BYTE2:   if (last_bit) state_d = S_ACK_2;
                S_ACK_2:   if (scl_fall && ack_on_q) state_d = S_OVERRUN;
                S_OVERRUN: if (last_bit) state_d = S_IGNORE;
`ifdef I2C_SLV_RD_EN
                S_RD_ACK:  if (scl_fall && ack_on_q) state_d = S_TX;
                S_TX:      if (scl_fall && (bit_cnt_q == 4'd8)) state_d = S_TX_MACK;
                S_TX_MACK: if (scl_rise) state_d = (sda || tx_second_q) ? S_IGNORE : S_TX;
`endif
                default: ;
            endcase
        end
    end

`ifdef I2C_SLV_RD_EN
    // Register addressed by the read pointer; out-of-range pointers read as zero
    always_comb begin
        ptr_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ptr_q == 7'(i)) ptr_data = regs_q[i];
        end
    end
`endif

    // Output/datapath logic: shifting, ACK drive, commit and error accounting
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hi_d      = hi_q;
        ack_on_d  = ack_on_q;
        sda_oe_d  = sda_oe_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        err_inc   = 1'b0;
        regs_d    = regs_q;
`ifdef I2C_SLV_RD_EN
        ptr_d       = ptr_q;
        tx_d        = tx_q;
        tx_second_d = tx_second_q;
`endif
        if (stop_det || start_det) begin
            sda_oe_d  = 1'b0;
            ack_on_d  = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
            err_inc   = partial;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE1, S_BYTE2, S_OVERRUN: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (state_q == S_ADDR) begin
                            err_inc = !addr_wr && !addr_rd;
`ifdef I2C_SLV_RD_EN
                            tx_d        = {ptr_q, ptr_data[8]};
                            tx_second_d = 1'b0;
`endif
                        end else if (state_q == S_BYTE1) begin
                            hi_d = shift_in;
                        end else if (state_q == S_BYTE2) begin
                            we_d   = 1'b1;
                            addr_d = hi_q[7:1];
                            data_d = {hi_q[0], shift_in};
`ifdef I2C_SLV_RD_EN
                            ptr_d  = hi_q[7:1];
`endif
                            if (hi_q[7:1] == RESET_REG) begin
                                for (int i = 0; i < NUM_REGS; i++) regs_d[i] = reg_default(i);
                            end else begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (hi_q[7:1] == 7'(i)) regs_d[i] = {hi_q[0], shift_in};
                                end
                            end
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end
                S_ACK_A, S_ACK_1, S_ACK_2: begin
                    // First fall after bit 8 pulls SDA low, the next one releases it
                    if (scl_fall) begin
                        sda_oe_d = ~ack_on_q;
                        ack_on_d = ~ack_on_q;
                    end
                end
`ifdef I2C_SLV_RD_EN
                S_RD_ACK: begin
                    if (scl_fall) begin
                        ack_on_d  = ~ack_on_q;
                        sda_oe_d  = ack_on_q ? ~tx_q[7] : 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                S_TX: begin
                    if (scl_rise) begin
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall) sda_oe_d = (bit_cnt_q == 4'd8) ? 1'b0 : ~tx_q[7];
                end
                S_TX_MACK: begin
                    sda_oe_d = 1'b0;
                    if (scl_rise && !sda && !tx_second_q) begin
                        tx_d        = ptr_data[7:0];
                        tx_second_d = 1'b1;
                        bit_cnt_d   = '0;
                    end
                end
`endif
                default: sda_oe_d = 1'b0;
            endcase
        end
        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    // Datapath registers; register file reloads codec defaults on reset
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            hi_q      <= '0;
            ack_on_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
`ifdef I2C_SLV_RD_EN
            ptr_q       <= '0;
            tx_q        <= '0;
            tx_second_q <= 1'b0;
`endif
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hi_q      <= hi_d;
            ack_on_q  <= ack_on_d;
            sda_oe_q  <= sda_oe_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            regs_q    <= regs_d;
`ifdef I2C_SLV_RD_EN
            ptr_q       <= ptr_d;
            tx_q        <= tx_d;
            tx_second_q <= tx_second_d;
`endif
        end
    end

    // Asynchronous read port; indices past the file read as zero
    always_comb begin
        oRD_DATA = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (iRD_IDX == 4'(i)) oRD_DATA = regs_q[i];
        end
    end

    assign oREG_WE   = we_q;
    assign oREG_ADDR = addr_q;
    assign oREG_DATA = data_q;
    assign oBUSY     = (state_q != S_IDLE);
    assign oERR_CNT  = err_q;

endmodule

// File: tb/tb_i2c_codec_reg_slave.sv
// tb/tb_i2c_codec_reg_slave.sv - scoreboard bench for i2c_codec_reg_slave write path
module tb_i2c_codec_reg_slave;

    localparam int Q = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [3:0] rd_idx = 4'd0;
    wire        sda_bus;
    logic       reg_we;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic [8:0] rd_data;
    logic       busy;
    logic [7:0] err_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_we = 0;
    int          n_pushed = 0;
    logic [15:0] exp_q [$];
    logic [8:0]  dflt [10];

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_codec_reg_slave dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda_bus),
        .oREG_WE   (reg_we),
        .oREG_ADDR (reg_addr),
        .oREG_DATA (reg_data),
        .iRD_IDX   (rd_idx),
        .oRD_DATA  (rd_data),
        .oBUSY     (busy),
        .oERR_CNT  (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic [8:0] exp);
        rd_idx = 4'(idx);
        #1 check(tag, rd_data, exp);
        #9;
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        #Q m_sda_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_rstart();
        m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b0;
        #Q;
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i];
            #Q scl = 1'b1;
            #(2*Q) scl = 1'b0;
            #Q;
        end
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_ack);
        logic ack;
        send_bits(b);
        m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q ack = (sda_bus === 1'b0);
        #Q scl = 1'b0;
        #Q;
        check(tag, ack, exp_ack);
    endtask

    task automatic push_exp(input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back({b1, b2});
        n_pushed++;
    endtask

    task automatic wr3(input string t, input logic [7:0] b1, input logic [7:0] b2);
        i2c_start();
        send_byte({t, "_ack_dev"}, 8'h34, 1'b1);
        send_byte({t, "_ack_b1"}, b1, 1'b1);
        push_exp(b1, b2);
        send_byte({t, "_ack_b2"}, b2, 1'b1);
        i2c_stop();
    endtask

    // Scoreboard: every commit strobe must match the oldest queued write and last one cycle
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (reg_we) begin
                n_we++;
                check("we_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("we_word", {reg_addr, reg_data}, e);
                end
                @(negedge clk);
                check("we_one_cycle", reg_we, 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        dflt = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        #100 rst_n = 1'b1;
        #100;
        check("rst_we", reg_we, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_data", reg_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_cnt, 0);
        check("rst_sda", sda_bus, 1);
        for (int i = 0; i < 16; i++) rd_chk("rst_rd", i, (i < 10) ? dflt[i] : 9'h000);

        // Basic write R2 = 07B
        i2c_start();
        check("t1_busy", busy, 1);
        send_byte("t1_ack_dev", 8'h34, 1'b1);
        send_byte("t1_ack_b1", 8'h04, 1'b1);
        push_exp(8'h04, 8'h7B);
        send_byte("t1_ack_b2", 8'h7B, 1'b1);
        i2c_stop();
        check("t1_idle", busy, 0);
        rd_chk("t1_r2", 2, 9'h07B);
        check("t1_err", err_cnt, 0);

        // Data bit 8 comes from byte-1 LSB: R6 = 123
        wr3("t2", 8'h0D, 8'h23);
        rd_chk("t2_r6", 6, 9'h123);
        rd_chk("t2_r2", 2, 9'h07B);

        // Foreign address: NACK, bus left alone until STOP
        i2c_start();
        send_byte("t3_nack_addr", 8'h40, 1'b0);
        send_byte("t3_sda_released", 8'hFF, 1'b0);
        check("t3_busy", busy, 1);
        i2c_stop();
        check("t3_err", err_cnt, 1);

        // Repeated START drops partial write; index 0F restores defaults
        i2c_start();
        send_byte("t4_ack_dev", 8'h34, 1'b1);
        send_byte("t4_ack_b1", 8'h04, 1'b1);
        i2c_rstart();
        send_byte("t4_ack_dev2", 8'h34, 1'b1);
        send_byte("t4_ack_b1b", 8'h1E, 1'b1);
        push_exp(8'h1E, 8'h00);
        send_byte("t4_ack_b2", 8'h00, 1'b1);
        i2c_stop();
        rd_chk("t4_r2", 2, 9'h079);
        rd_chk("t4_r6", 6, 9'h09F);
        check("t4_err", err_cnt, 2);

        // Overrun: fourth byte is NACKed after the commit
        i2c_start();
        send_byte("t5_ack_dev", 8'h34, 1'b1);
        send_byte("t5_ack_b1", 8'h12, 1'b1);
        push_exp(8'h12, 8'h01);
        send_byte("t5_ack_b2", 8'h01, 1'b1);
        send_byte("t5_nack_b3", 8'hAA, 1'b0);
        i2c_stop();
        rd_chk("t5_r9", 9, 9'h001);
        check("t5_err", err_cnt, 3);

        // Reset while the byte-1 ACK is held low
        i2c_start();
        send_byte("t6_ack_dev", 8'h34, 1'b1);
        send_bits(8'h08);
        m_sda_low = 1'b0;
        #Q check("t6_ack_low", sda_bus, 0);
        rst_n = 1'b0;
        #1 check("t6_sda_released", sda_bus, 1);
        check("t6_busy", busy, 0);
        check("t6_err", err_cnt, 0);
        #9;
        rd_chk("t6_r9", 9, 9'h000);
        rd_chk("t6_r6", 6, 9'h09F);
        rst_n = 1'b1;
        #Q i2c_stop();
        wr3("t6b", 8'h08, 8'hF8);
        rd_chk("t6b_r4", 4, 9'h0F8);
        check("t6b_err", err_cnt, 0);

        // Index past the file: strobe only, nothing stored
        wr3("t7", 8'h16, 8'h55);
        rd_chk("t7_r4", 4, 9'h0F8);
        rd_chk("t7_r11", 11, 9'h000);
        rd_chk("t7_r9", 9, 9'h000);

        // STOP before commit counts as an aborted transfer
        i2c_start();
        send_byte("t8_ack_dev", 8'h34, 1'b1);
        send_byte("t8_ack_b1", 8'h04, 1'b1);
        i2c_stop();
        rd_chk("t8_r2", 2, 9'h079);
        check("t8_err", err_cnt, 1);
        check("t8_busy", busy, 0);

        #(4*Q);
        check("sb_empty", exp_q.size(), 0);
        check("we_count", n_we, n_pushed);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
